// File: rtl/data_mem_unit_if.sv
// data_mem_unit_if: CPU data bus (address, bidirectional data, direction)
interface data_mem_unit_if;
   logic [15:0] da;
   wire  [15:0] dd;
   logic        rw;
   modport master(output da, rw, inout dd);
   modport slave(input da, rw, inout dd);
endinterface

// File: rtl/data_mem_unit.sv
// data_mem_unit: negedge-accessed data memory with host preload, result register and run-cycle counter
module data_mem_unit #(
   parameter int DEPTH    = 128,
   parameter int RES_ADDR = 2,
   parameter int CNT_W    = 16
) (
   input  logic               ck,
   input  logic               rst,
   data_mem_unit_if.slave     bus,
   input  logic               ld_en,
   input  logic [6:0]         ld_addr,
   input  logic [15:0]        ld_data,
   output logic [15:0]        result,
   output logic               done,
   output logic               err,
   output logic [CNT_W-1:0]   cycles
);
   localparam int          aw  = $clog2(DEPTH);
   localparam logic [15:0] top = 16'(DEPTH);
   localparam logic [15:0] res = 16'(RES_ADDR);
   logic [15:0]   mem [DEPTH];
   logic [15:0]   rdata, wdata;
   logic [aw-1:0] waddr;
   logic          in_range, store, we;
   // an unknown rw leaves store unknown, so neither the write nor the store branch is taken
   always_comb begin
      in_range = bus.da < top;
      store    = bus.rw == 1'b0;
      we       = rst ? ld_en : store && in_range;
      waddr    = rst ? ld_addr[aw-1:0] : bus.da[aw-1:0];
      wdata    = rst ? ld_data : bus.dd;
   end
   always_ff @(negedge ck)
      if (we) mem[waddr] <= wdata;
   always_ff @(negedge ck or posedge rst)
      if (rst) begin
         rdata  <= '0;
         result <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         err <= err | !in_range;
         if (store) begin
            if (in_range && bus.da == res) begin
               result <= bus.dd;
               done   <= 1'b1;
            end
         end else
            rdata <= in_range ? mem[bus.da[aw-1:0]] : '0;
      end
   always_ff @(posedge ck or posedge rst)
      if (rst) cycles <= '0;
      else if (!done && cycles != '1) cycles <= cycles + 1'b1;
   assign bus.dd = (!rst && bus.rw) ? rdata : 'z;
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: table-driven bus vectors plus reset, preload and counter saturation sequences
module tb_data_mem_unit;
   logic        ck = 1'b0, rst = 1'b1, ld_en = 1'b0, tb_oe = 1'b0;
   logic [6:0]  ld_addr = '0;
   logic [15:0] ld_data = '0, tb_dd = '0;
   logic [15:0] result, result4;
   logic        done, err, done4, err4;
   logic [15:0] cycles;
   logic [3:0]  cycles4;
   int          tests = 0, fails = 0;
   data_mem_unit_if bus();
   data_mem_unit_if bus4();
   assign bus.dd = tb_oe ? tb_dd : 'z;
   data_mem_unit dut (.ck(ck), .rst(rst), .bus(bus), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
                      .result(result), .done(done), .err(err), .cycles(cycles));
   data_mem_unit #(.CNT_W(4)) dut4 (.ck(ck), .rst(rst), .bus(bus4), .ld_en(1'b0), .ld_addr(7'd0), .ld_data(16'd0),
                      .result(result4), .done(done4), .err(err4), .cycles(cycles4));
   always #5 ck = ~ck;
   typedef struct {
      logic        rw;
      logic [15:0] da, wd, dd, res;
      logic        err, done;
      int          cyc;
   } vec_t;
   vec_t v[13];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic preload(input logic [6:0] a, input logic [15:0] d);
      @(posedge ck); #1;
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge ck); #1;
      ld_en = 1'b0;
   endtask
   task automatic bus_op(input logic rw, input logic [15:0] da, input logic [15:0] wd);
      @(posedge ck); #1;
      bus.rw = rw; bus.da = da; tb_dd = wd; tb_oe = !rw;
      @(negedge ck); #1;
   endtask
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      bus.rw = 1'b1; bus.da = '0; bus4.rw = 1'b1; bus4.da = '0;
      v[0]  = '{1'b1, 16'd1,   16'd0,    16'd255,    16'd0,   1'b0, 1'b0, 1};
      v[1]  = '{1'b1, 16'd0,   16'd0,    16'd2,      16'd0,   1'b0, 1'b0, 2};
      v[2]  = '{1'b1, 16'd5,   16'd0,    16'hBEEF,   16'd0,   1'b0, 1'b0, 3};
      v[3]  = '{1'b0, 16'd3,   16'd1234, 16'd0,      16'd0,   1'b0, 1'b0, 4};
      v[4]  = '{1'b1, 16'd3,   16'd0,    16'd1234,   16'd0,   1'b0, 1'b0, 5};
      v[5]  = '{1'b0, 16'd2,   16'd510,  16'd0,      16'd510, 1'b0, 1'b1, 6};
      v[6]  = '{1'b1, 16'd2,   16'd0,    16'd510,    16'd510, 1'b0, 1'b1, 6};
      v[7]  = '{1'b0, 16'd2,   16'd77,   16'd0,      16'd77,  1'b0, 1'b1, 6};
      v[8]  = '{1'b1, 16'd127, 16'd0,    16'h7F7F,   16'd77,  1'b0, 1'b1, 6};
      v[9]  = '{1'b1, 16'd128, 16'd0,    16'd0,      16'd77,  1'b1, 1'b1, 6};
      v[10] = '{1'b1, 16'd1,   16'd0,    16'd255,    16'd77,  1'b1, 1'b1, 6};
      v[11] = '{1'b0, 16'd200, 16'd9,    16'd0,      16'd77,  1'b1, 1'b1, 6};
      v[12] = '{1'b1, 16'd72,  16'd0,    16'h0048,   16'd77,  1'b1, 1'b1, 6};
      preload(7'd0, 16'd2);
      preload(7'd1, 16'd255);
      preload(7'd5, 16'hBEEF);
      preload(7'd6, 16'h0606);
      preload(7'd127, 16'h7F7F);
      preload(7'd72, 16'h0048);
      chk("reset result", result, 0);
      chk("reset done", done, 0);
      chk("reset err", err, 0);
      chk("reset cycles", cycles, 0);
      @(posedge ck); #1;
      rst = 1'b0;
      for (int i = 0; i < 13; i++) begin
         bus_op(v[i].rw, v[i].da, v[i].wd);
         if (v[i].rw) chk($sformatf("v%0d dd", i), bus.dd, v[i].dd);
         chk($sformatf("v%0d err", i), err, v[i].err);
         chk($sformatf("v%0d result", i), result, v[i].res);
         chk($sformatf("v%0d done", i), done, v[i].done);
         chk($sformatf("v%0d cycles", i), cycles, v[i].cyc);
      end
      // preload strobe outside reset must not touch memory
      @(posedge ck); #1;
      ld_en = 1'b1; ld_addr = 7'd6; ld_data = 16'hDEAD; bus.rw = 1'b1; bus.da = '0; tb_oe = 1'b0;
      @(negedge ck); #1;
      ld_en = 1'b0;
      bus_op(1'b1, 16'd6, 16'd0);
      chk("ld ignored run", bus.dd, 16'h0606);
      @(posedge ck); #1;
      rst = 1'b1;
      #1;
      chk("async rst result", result, 0);
      chk("async rst done", done, 0);
      chk("async rst err", err, 0);
      chk("async rst cycles", cycles, 0);
      chk("async rst cycles4", cycles4, 0);
      bus.rw = 1'b0; bus.da = 16'd2; tb_dd = 16'd999; tb_oe = 1'b1;
      preload(7'd6, 16'hBEEF);
      chk("bus store ignored in rst", result, 0);
      bus.rw = 1'b1; tb_oe = 1'b0;
      @(posedge ck); #1;
      rst = 1'b0;
      bus_op(1'b1, 16'd2, 16'd0);
      chk("mem kept over rst", bus.dd, 16'd77);
      chk("post rst done", done, 0);
      chk("post rst cycles", cycles, 1);
      bus_op(1'b1, 16'd6, 16'd0);
      chk("preload under rst", bus.dd, 16'hBEEF);
      chk("post rst err", err, 0);
      repeat (20) @(posedge ck);
      #1;
      chk("run cycles", cycles, 22);
      chk("sat cycles4", cycles4, 15);
      repeat (3) @(posedge ck);
      #1;
      chk("sat held cycles4", cycles4, 15);
      chk("run cycles later", cycles, 25);
      chk("cnt4 done", done4, 0);
      chk("cnt4 err", err4, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
